// File: rtl/dff_mux_4to1_pkg.sv
// Shared select encoding and defaults for the registered 4:1 multiplexer.
package dff_mux_4to1_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_X0 = 2'd0;
   localparam sel_t SEL_X1 = 2'd1;
   localparam sel_t SEL_X2 = 2'd2;
   localparam sel_t SEL_X3 = 2'd3;

   localparam logic [63:0] DEFAULT_RESET_VAL = 64'd0;

endpackage

// File: rtl/mux_4to1_comb.sv
// Purely combinational WIDTH-bit 4:1 multiplexer; select uses the package encoding.
module mux_4to1_comb
   import dff_mux_4to1_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_x0,
   input  logic [WIDTH-1:0] i_x1,
   input  logic [WIDTH-1:0] i_x2,
   input  logic [WIDTH-1:0] i_x3,
   input  sel_t             i_sel,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_sel)
         SEL_X0:  o_y = i_x0;
         SEL_X1:  o_y = i_x1;
         SEL_X2:  o_y = i_x2;
         SEL_X3:  o_y = i_x3;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/dff_mux_4to1.sv
// Registered 4:1 mux: f <= x[{s1,s0}] each rising edge, synchronous reset to RESET_VAL.
// Define DFF_MUX_4TO1_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module dff_mux_4to1
   import dff_mux_4to1_pkg::*;
#(
   parameter int unsigned WIDTH     = 1,
   parameter logic [63:0] RESET_VAL = DEFAULT_RESET_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic [WIDTH-1:0] x3,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] f
);

   // RESET_VAL is carried as 64 bits so any legal WIDTH can truncate it.
   localparam logic [WIDTH-1:0] L_RST_VAL = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] w_x0;
   logic [WIDTH-1:0] w_x1;
   logic [WIDTH-1:0] w_x2;
   logic [WIDTH-1:0] w_x3;
   sel_t             w_sel;
   logic [WIDTH-1:0] w_mux;
   logic [WIDTH-1:0] r_f;

`ifdef DFF_MUX_4TO1_IN_REG_EN
   logic [WIDTH-1:0] r_x0;
   logic [WIDTH-1:0] r_x1;
   logic [WIDTH-1:0] r_x2;
   logic [WIDTH-1:0] r_x3;
   sel_t             r_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x0  <= '0;
         r_x1  <= '0;
         r_x2  <= '0;
         r_x3  <= '0;
         r_sel <= SEL_X0;
      end else begin
         r_x0  <= x0;
         r_x1  <= x1;
         r_x2  <= x2;
         r_x3  <= x3;
         r_sel <= sel_t'({s1, s0});
      end
   end

   assign w_x0  = r_x0;
   assign w_x1  = r_x1;
   assign w_x2  = r_x2;
   assign w_x3  = r_x3;
   assign w_sel = r_sel;
`else
   assign w_x0  = x0;
   assign w_x1  = x1;
   assign w_x2  = x2;
   assign w_x3  = x3;
   assign w_sel = sel_t'({s1, s0});
`endif

   mux_4to1_comb #(
      .WIDTH (WIDTH)
   ) u_mux (
      .i_x0  (w_x0),
      .i_x1  (w_x1),
      .i_x2  (w_x2),
      .i_x3  (w_x3),
      .i_sel (w_sel),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_f <= L_RST_VAL;
      end else begin
         r_f <= w_mux;
      end
   end

   assign f = r_f;

endmodule

// File: tb/tb_dff_mux_4to1.sv
// Directed self-checking bench for dff_mux_4to1 (covers both the base and input-register builds).
module tb_dff_mux_4to1;

   localparam int unsigned WIDTH = 8;
`ifdef DFF_MUX_4TO1_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] x0, x1, x2, x3;
   logic             s0, s1;
   logic [WIDTH-1:0] f;

   int total;
   int bad;

   dff_mux_4to1 #(
      .WIDTH     (WIDTH),
      .RESET_VAL (64'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .x0  (x0),
      .x1  (x1),
      .x2  (x2),
      .x3  (x3),
      .s0  (s0),
      .s1  (s1),
      .f   (f)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_lat();
      for (int i = 0; i < LAT; i++) tick();
   endtask

   task automatic drive(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                        input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                        input logic [1:0] sel);
      x0 = a0; x1 = a1; x2 = a2; x3 = a3;
      s1 = sel[1]; s0 = sel[0];
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(8'h01, 8'h01, 8'h01, 8'h01, 2'b00);
      rst = 1'b1;
      tick();
      total++;
      if (f !== 8'h00) begin
         bad++;
         $display("FAIL reset_value: got %h expected %h", f, 8'h00);
      end
      rst = 1'b0;
      wait_lat();
      total++;
      if (f !== 8'h01) begin
         bad++;
         $display("FAIL reset_release: got %h expected %h", f, 8'h01);
      end
   endtask

   task automatic test_all_zero();
      drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      wait_lat();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (f !== 8'h00) begin
            bad++;
            $display("FAIL all_zero[%0d]: got %h expected %h", i, f, 8'h00);
         end
         tick();
      end
   endtask

   task automatic test_select_x0();
      drive(8'h01, 8'h00, 8'h00, 8'h01, 2'b00);
      wait_lat();
      total++;
      if (f !== 8'h01) begin
         bad++;
         $display("FAIL select_x0: got %h expected %h", f, 8'h01);
      end
   endtask

   task automatic test_select_x2();
      s1 = 1'b1; s0 = 1'b0;
      wait_lat();
      total++;
      if (f !== 8'h00) begin
         bad++;
         $display("FAIL select_x2_zero: got %h expected %h", f, 8'h00);
      end
      x2 = 8'h01;
      wait_lat();
      total++;
      if (f !== 8'h01) begin
         bad++;
         $display("FAIL select_x2_one: got %h expected %h", f, 8'h01);
      end
   endtask

   // One-hot then inverse one-hot per select; f must also hold while inputs move mid-cycle.
   task automatic test_sweep();
      logic [WIDTH-1:0] oh [4];
      logic [WIDTH-1:0] exp_v;
      for (int s = 0; s < 4; s++) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++)
               oh[k] = ((k == s) ^ (pass == 1)) ? ((pass == 0) ? 8'hA5 : 8'hFF) : 8'h00;
            exp_v = (pass == 0) ? 8'hA5 : 8'h00;
            drive(oh[0], oh[1], oh[2], oh[3], 2'(s));
            wait_lat();
            total++;
            if (f !== exp_v) begin
               bad++;
               $display("FAIL sweep sel=%0d pass=%0d: got %h expected %h", s, pass, f, exp_v);
            end
            drive(8'h5A, 8'h3C, 8'hC3, 8'h96, 2'(3 - s));
            #2;
            total++;
            if (f !== exp_v) begin
               bad++;
               $display("FAIL sweep_hold sel=%0d pass=%0d: got %h expected %h", s, pass, f, exp_v);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      drive(8'h00, 8'h01, 8'h00, 8'h00, 2'b01);
      wait_lat();
      total++;
      if (f !== 8'h01) begin
         bad++;
         $display("FAIL mid_pre: got %h expected %h", f, 8'h01);
      end
      rst = 1'b1;
      tick();
      total++;
      if (f !== 8'h00) begin
         bad++;
         $display("FAIL mid_reset: got %h expected %h", f, 8'h00);
      end
      rst = 1'b0;
      wait_lat();
      total++;
      if (f !== 8'h01) begin
         bad++;
         $display("FAIL mid_release: got %h expected %h", f, 8'h01);
      end
   endtask

   // A reset pulse that starts and ends between edges must be invisible.
   task automatic test_reset_between_edges();
      drive(8'h00, 8'h00, 8'h00, 8'h7E, 2'b11);
      wait_lat();
      rst = 1'b1;
      #2;
      total++;
      if (f !== 8'h7E) begin
         bad++;
         $display("FAIL rst_async_effect: got %h expected %h", f, 8'h7E);
      end
      rst = 1'b0;
      tick();
      total++;
      if (f !== 8'h7E) begin
         bad++;
         $display("FAIL rst_glitch_edge: got %h expected %h", f, 8'h7E);
      end
   endtask

   // New select and data every cycle; f lags the driven vector by LAT edges.
   task automatic test_back_to_back();
      logic [1:0]       sel_tab [6];
      logic [WIDTH-1:0] exp_tab [6];
      logic [WIDTH-1:0] exp_q [$];
      logic [WIDTH-1:0] exp_v;
      sel_tab = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
      exp_tab = '{8'h11, 8'h88, 8'h22, 8'h44, 8'h44, 8'h11};
      exp_q = {};
      for (int k = 0; k < 6 + LAT - 1; k++) begin
         if (k < 6) begin
            drive(8'h11, 8'h22, 8'h44, 8'h88, sel_tab[k]);
            exp_q.push_back(exp_tab[k]);
         end
         tick();
         if (k >= LAT - 1) begin
            exp_v = exp_q.pop_front();
            total++;
            if (f !== exp_v) begin
               bad++;
               $display("FAIL back_to_back[%0d]: got %h expected %h", k, f, exp_v);
            end
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
      @(negedge clk);
      test_reset();
      test_all_zero();
      test_select_x0();
      test_select_x2();
      test_sweep();
      test_midstream_reset();
      test_reset_between_edges();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dff_mux_4to1.md
Name: dff_mux_4to1

Overview:
- Registered 4:1 multiplexer: one of four data inputs is chosen by a 2-bit select (s1:s0) and captured into a flip-flop on the rising clock edge.
- Output `f` is glitch-free and changes only on clock edges.
- Used as a registered selection point in datapath/control glue, e.g. choosing among operand or status sources.

Parameters:
- WIDTH, 1, bit width of each data input x0..x3 and of output f (legal range 1..64).
- RESET_VAL, 0, value loaded into f by reset (WIDTH bits, zero-extended/truncated).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- x0, input, WIDTH, data input selected when {s1,s0}=2'b00.
- x1, input, WIDTH, data input selected when {s1,s0}=2'b01.
- x2, input, WIDTH, data input selected when {s1,s0}=2'b10.
- x3, input, WIDTH, data input selected when {s1,s0}=2'b11.
- s0, input, 1, select LSB.
- s1, input, 1, select MSB.
- f, output, WIDTH, registered mux output.

Behaviour:
- Select encoding: sel = {s1,s0}; s1 is the MSB. 0→x0, 1→x1, 2→x2, 3→x3.
- Every rising clk edge with rst=1: f <= RESET_VAL. Reset has priority over data and is sampled only on clk edges; rst has no effect between edges.
- Every rising clk edge with rst=0: f <= x[sel], using the values of x0..x3, s0 and s1 present immediately before the edge.
- Latency: 1 cycle from input/select change to f (base build).
- f holds its value between edges; combinational changes on the inputs never propagate to f asynchronously.
- Power-up before the first reset: f is undefined in RTL. The bench must apply reset, or treat f as X until the first edge.
- Simultaneous select and data change before the same edge: the new select with the new data is captured.
- X/Z on s0 or s1: no requirement on f beyond simulation X-propagation. The implementation must not latch or hold its previous value.
- Reset asserted mid-stream: the next edge loads RESET_VAL. The first edge after deassertion loads x[sel].
- No enable; f updates every cycle.

Optional Feature:
- Macro: DFF_MUX_4TO1_IN_REG_EN.
- Defined: x0..x3, s0 and s1 are first captured into an input register stage, and the mux operates on the registered copies. Latency becomes 2 cycles from input change to f. rst clears the input stage registers to 0 and f to RESET_VAL on the same edge.
- Undefined: no input stage; latency is 1 cycle as above.

Decomposition:
- Package dff_mux_4to1_pkg holds:
  - select encoding constants SEL_X0=2'd0, SEL_X1=2'd1, SEL_X2=2'd2, SEL_X3=2'd3;
  - a sel_t 2-bit typedef;
  - a default RESET_VAL constant.
- Sub-module mux_4to1_comb: purely combinational WIDTH-bit 4:1 mux. The top module instantiates it and adds the output register, plus the optional input stage.

Test Plan:
- Reset: rst=1 for 1 edge with x0..x3=1, sel=00 → f=0 after the edge. Deassert rst → f=1 after the next edge.
- All zero: x0..x3=0, sel=00 → f=0 on every edge.
- Select x0: x0=1, x1=0, x2=0, x3=1, sel=00 → f=1 after 1 edge (2 edges with DFF_MUX_4TO1_IN_REG_EN).
- Select x2: keep data from the previous case, set s1=1, s0=0 → f=0 after 1 edge. Then set x2=1 → f=1 on the next edge.
- Exhaustive sweep: for each sel 0..3 drive one-hot x (only the selected input=1), then inverse one-hot → f follows x[sel] one cycle later. Check no change in f between edges.
- Mid-stream reset: with f=1, assert rst for one edge while inputs keep selecting a 1 → f=RESET_VAL (0). Release → f=1 on the next edge.
